// File: rtl/pipe_control_unit.sv
// ID-stage decoder and ID/EX control register for the 5-stage RISC-V core,
// with load-use stall, branch flush and an optional multi-cycle MUL busy counter.
module pipe_control_unit #(
    parameter int unsigned OP_W       = 4,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned ENABLE_MUL = 1,
    parameter int unsigned MUL_LAT    = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       instr_i,
    input  logic              id_valid_i,
    input  logic              flush_i,
    output logic [OP_W-1:0]   ex_operation_o,
    output logic              ex_alusrc_o,
    output logic              ex_regwrite_o,
    output logic              ex_memread_o,
    output logic              ex_memwrite_o,
    output logic              ex_memtoreg_o,
    output logic              ex_branch_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              ex_valid_o,
    output logic              stall_o
);

    localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    localparam logic [6:0] OPC_ADDI = 7'b0010011;
    localparam logic [6:0] OPC_LW   = 7'b0000011;
    localparam logic [6:0] OPC_SW   = 7'b0100011;
    localparam logic [6:0] OPC_BEQ  = 7'b1100011;
    localparam logic [6:0] OPC_R    = 7'b0110011;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic              alusrc;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic              memtoreg;
        logic              branch;
        logic [REG_AW-1:0] rd;
        logic              valid;
    } ctrl_t;

    ctrl_t             dec_c;
    ctrl_t             ex_d;
    ctrl_t             ex_q;
    logic              is_mul_c;
    logic              rs2_used_c;
    logic              load_use_c;
    logic [CNT_W-1:0]  mul_cnt_d;
    logic [CNT_W-1:0]  mul_cnt_q;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [REG_AW-1:0] rd_f;
    logic [REG_AW-1:0] rs1_f;
    logic [REG_AW-1:0] rs2_f;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign rd_f   = REG_AW'(instr_i[11:7]);
    assign rs1_f  = REG_AW'(instr_i[19:15]);
    assign rs2_f  = REG_AW'(instr_i[24:20]);

    // Instruction decode; unknown opcodes decode to an invalid (bubble) bundle
    always_comb begin
        dec_c      = '0;
        dec_c.op   = OP_W'(4'b1000);
        is_mul_c   = 1'b0;
        rs2_used_c = 1'b0;
        case (opcode)
            OPC_ADDI: begin
                dec_c.op       = OP_W'(4'b0000);
                dec_c.alusrc   = 1'b1;
                dec_c.regwrite = 1'b1;
                dec_c.rd       = rd_f;
                dec_c.valid    = 1'b1;
            end
            OPC_LW: begin
                dec_c.op       = OP_W'(4'b0101);
                dec_c.alusrc   = 1'b1;
                dec_c.regwrite = 1'b1;
                dec_c.memread  = 1'b1;
                dec_c.memtoreg = 1'b1;
                dec_c.rd       = rd_f;
                dec_c.valid    = 1'b1;
            end
            OPC_SW: begin
                dec_c.op       = OP_W'(4'b0110);
                dec_c.alusrc   = 1'b1;
                dec_c.memwrite = 1'b1;
                dec_c.valid    = 1'b1;
                rs2_used_c     = 1'b1;
            end
            OPC_BEQ: begin
                dec_c.op     = OP_W'(4'b0111);
                dec_c.branch = 1'b1;
                dec_c.valid  = 1'b1;
                rs2_used_c   = 1'b1;
            end
            OPC_R: begin
                dec_c.regwrite = 1'b1;
                dec_c.rd       = rd_f;
                dec_c.valid    = 1'b1;
                rs2_used_c     = 1'b1;
                if (funct7 == 7'b0100000) begin
                    dec_c.op = OP_W'(4'b0001);
                end else if (funct7 == 7'b0000001 && ENABLE_MUL != 0) begin
                    dec_c.op = OP_W'(4'b1001);
                    is_mul_c = 1'b1;
                end else begin
                    case (funct3)
                        3'b111:  dec_c.op = OP_W'(4'b0010);
                        3'b110:  dec_c.op = OP_W'(4'b0011);
                        3'b100:  dec_c.op = OP_W'(4'b1010);
                        3'b001:  dec_c.op = OP_W'(4'b1011);
                        default: dec_c.op = OP_W'(4'b1000);
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Load in EX whose destination feeds the ID instruction
    always_comb begin
        load_use_c = ex_q.valid & ex_q.memread & (ex_q.rd != '0) & id_valid_i &
                     ((ex_q.rd == rs1_f) | (rs2_used_c & (ex_q.rd == rs2_f)));
        stall_o    = load_use_c | (mul_cnt_q != '0);
    end

    // Next ID/EX contents; flush outranks stall, stall outranks an empty slot
    always_comb begin
        ex_d      = '0;
        mul_cnt_d = mul_cnt_q;
        if (mul_cnt_q != '0) begin
            mul_cnt_d = mul_cnt_q - CNT_W'(1);
        end
        if (flush_i || stall_o || !id_valid_i) begin
            ex_d = '0;
        end else begin
            ex_d = dec_c;
            if (is_mul_c) begin
                mul_cnt_d = CNT_W'(MUL_LAT - 1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q      <= '0;
            mul_cnt_q <= '0;
        end else begin
            ex_q      <= ex_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    assign ex_operation_o = ex_q.op;
    assign ex_alusrc_o    = ex_q.alusrc;
    assign ex_regwrite_o  = ex_q.regwrite;
    assign ex_memread_o   = ex_q.memread;
    assign ex_memwrite_o  = ex_q.memwrite;
    assign ex_memtoreg_o  = ex_q.memtoreg;
    assign ex_branch_o    = ex_q.branch;
    assign ex_rd_o        = ex_q.rd;
    assign ex_valid_o     = ex_q.valid;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Bench for pipe_control_unit: a MUL-enabled and a MUL-disabled instance share
// stimulus and are compared against a mnemonic-level reference model.
module tb_pipe_control_unit;

    localparam int MUL_LAT = 3;

    typedef struct packed {
        logic [3:0] op;
        logic       alusrc;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       branch;
        logic [4:0] rd;
        logic       valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        idv;
    logic        flush;
    logic [31:0] instr;

    logic [3:0] o_op  [2];
    logic       o_alu [2];
    logic       o_rw  [2];
    logic       o_mr  [2];
    logic       o_mw  [2];
    logic       o_mtr [2];
    logic       o_br  [2];
    logic [4:0] o_rd  [2];
    logic       o_v   [2];
    logic       o_st  [2];

    int   total = 0;
    int   bad   = 0;
    exp_t m    [2];
    int   busy [2];

    always #5 clk = ~clk;

    pipe_control_unit #(.OP_W(4), .REG_AW(5), .ENABLE_MUL(1), .MUL_LAT(MUL_LAT)) dut (
        .clk_i(clk), .rst_i(rst), .instr_i(instr), .id_valid_i(idv), .flush_i(flush),
        .ex_operation_o(o_op[0]), .ex_alusrc_o(o_alu[0]), .ex_regwrite_o(o_rw[0]),
        .ex_memread_o(o_mr[0]), .ex_memwrite_o(o_mw[0]), .ex_memtoreg_o(o_mtr[0]),
        .ex_branch_o(o_br[0]), .ex_rd_o(o_rd[0]), .ex_valid_o(o_v[0]), .stall_o(o_st[0])
    );

    pipe_control_unit #(.OP_W(4), .REG_AW(5), .ENABLE_MUL(0), .MUL_LAT(MUL_LAT)) dut_nomul (
        .clk_i(clk), .rst_i(rst), .instr_i(instr), .id_valid_i(idv), .flush_i(flush),
        .ex_operation_o(o_op[1]), .ex_alusrc_o(o_alu[1]), .ex_regwrite_o(o_rw[1]),
        .ex_memread_o(o_mr[1]), .ex_memwrite_o(o_mw[1]), .ex_memtoreg_o(o_mtr[1]),
        .ex_branch_o(o_br[1]), .ex_rd_o(o_rd[1]), .ex_valid_o(o_v[1]), .stall_o(o_st[1])
    );

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'h004, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1);
        return {7'b0000000, rs2, rs1, 3'b010, 5'b01000, 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_beq(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, 5'b10100, 7'b1100011};
    endfunction

    // What the ISA table says each instruction should put into EX
    function automatic exp_t ref_decode(input logic [31:0] ins, input bit mul_en);
        exp_t e;
        e    = '0;
        e.op = 4'b1000;
        case (ins[6:0])
            7'b0010011: begin e.op = 4'b0000; e.alusrc = 1; e.regwrite = 1; e.rd = ins[11:7]; e.valid = 1; end
            7'b0000011: begin e.op = 4'b0101; e.alusrc = 1; e.regwrite = 1; e.memread = 1;
                              e.memtoreg = 1; e.rd = ins[11:7]; e.valid = 1; end
            7'b0100011: begin e.op = 4'b0110; e.alusrc = 1; e.memwrite = 1; e.valid = 1; end
            7'b1100011: begin e.op = 4'b0111; e.branch = 1; e.valid = 1; end
            7'b0110011: begin
                e.regwrite = 1; e.rd = ins[11:7]; e.valid = 1;
                if (ins[31:25] == 7'b0100000)                e.op = 4'b0001;
                else if (ins[31:25] == 7'b0000001 && mul_en) e.op = 4'b1001;
                else if (ins[14:12] == 3'b111)               e.op = 4'b0010;
                else if (ins[14:12] == 3'b110)               e.op = 4'b0011;
                else if (ins[14:12] == 3'b100)               e.op = 4'b1010;
                else if (ins[14:12] == 3'b001)               e.op = 4'b1011;
                else                                         e.op = 4'b1000;
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic bit model_stall(input int k);
        bit reads_rs2;
        bit hazard;
        reads_rs2 = (instr[6:0] == 7'b0110011) || (instr[6:0] == 7'b0100011) ||
                    (instr[6:0] == 7'b1100011);
        hazard = m[k].valid && m[k].memread && (m[k].rd != 0) && idv &&
                 ((instr[19:15] == m[k].rd) || (reads_rs2 && instr[24:20] == m[k].rd));
        return hazard || (busy[k] > 0);
    endfunction

    function automatic exp_t obs(input int k);
        return {o_op[k], o_alu[k], o_rw[k], o_mr[k], o_mw[k], o_mtr[k], o_br[k], o_rd[k], o_v[k]};
    endfunction

    task automatic drive(input logic r, input logic v, input logic f, input logic [31:0] ins);
        rst   = r;
        idv   = v;
        flush = f;
        instr = ins;
        #1;
    endtask

    // Advance one clock, updating the reference model from the current inputs
    task automatic tick();
        exp_t nx [2];
        int   nb [2];
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                nx[k] = '0;
                nb[k] = 0;
            end else begin
                nb[k] = (busy[k] > 0) ? busy[k] - 1 : 0;
                if (flush || model_stall(k) || !idv) begin
                    nx[k] = '0;
                end else begin
                    nx[k] = ref_decode(instr, k == 0);
                    if (k == 0 && nx[k].op == 4'b1001) nb[k] = MUL_LAT - 1;
                end
            end
        end
        @(posedge clk);
        m    = nx;
        busy = nb;
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 0, enc_addi(5'd1, 5'd0, 12'd5));
        tick();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs(k) !== exp_t'(0)) begin
                bad++;
                $display("FAIL reset_ex[%0d] got=%h want=0000", k, obs(k));
            end
            total++;
            if (o_st[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_stall[%0d] got=%b want=0", k, o_st[k]);
            end
        end
    endtask

    task automatic test_addi();
        drive(0, 1, 0, 32'h00500093);
        tick();
        total++;
        if (obs(0) !== {4'b0000, 6'b110000, 5'd1, 1'b1}) begin
            bad++;
            $display("FAIL addi_ex got=%h want=%h", obs(0), {4'b0000, 6'b110000, 5'd1, 1'b1});
        end
    endtask

    task automatic test_load_use();
        drive(0, 1, 0, enc_lw(5'd2, 5'd1));
        tick();
        drive(0, 1, 0, enc_r(7'b0, 5'd1, 5'd2, 3'b000, 5'd3));
        total++;
        if (o_st[0] !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b want=1", o_st[0]); end
        tick();
        total++;
        if (o_v[0] !== 1'b0 || o_rw[0] !== 1'b0) begin
            bad++; $display("FAIL lu_bubble got valid=%b rw=%b want 0 0", o_v[0], o_rw[0]);
        end
        total++;
        if (o_st[0] !== 1'b0) begin bad++; $display("FAIL lu_stall_drop got=%b want=0", o_st[0]); end
        tick();
        total++;
        if (o_op[0] !== 4'b1000 || o_rd[0] !== 5'd3 || o_v[0] !== 1'b1) begin
            bad++; $display("FAIL lu_add got op=%b rd=%0d v=%b want 1000 3 1", o_op[0], o_rd[0], o_v[0]);
        end
    endtask

    task automatic test_x0_and_sw();
        drive(0, 1, 0, enc_lw(5'd0, 5'd1));
        tick();
        drive(0, 1, 0, enc_r(7'b0, 5'd0, 5'd0, 3'b000, 5'd3));
        total++;
        if (o_st[0] !== 1'b0) begin bad++; $display("FAIL x0_stall got=%b want=0", o_st[0]); end
        tick();
        drive(0, 1, 0, enc_lw(5'd2, 5'd1));
        tick();
        drive(0, 1, 0, enc_sw(5'd5, 5'd2));
        total++;
        if (o_st[0] !== 1'b1) begin bad++; $display("FAIL sw_stall got=%b want=1", o_st[0]); end
        tick();
        total++;
        if (o_v[0] !== 1'b0 || o_st[0] !== 1'b0) begin
            bad++; $display("FAIL sw_bubble got v=%b stall=%b want 0 0", o_v[0], o_st[0]);
        end
        tick();
        total++;
        if (obs(0) !== {4'b0110, 6'b100100, 5'd0, 1'b1}) begin
            bad++; $display("FAIL sw_issue got=%h want=%h", obs(0), {4'b0110, 6'b100100, 5'd0, 1'b1});
        end
    endtask

    task automatic test_mul();
        drive(0, 1, 0, enc_r(7'b0000001, 5'd6, 5'd5, 3'b000, 5'd4));
        tick();
        total++;
        if (o_op[0] !== 4'b1001 || o_op[1] !== 4'b1000) begin
            bad++; $display("FAIL mul_op got en=%b dis=%b want 1001 1000", o_op[0], o_op[1]);
        end
        drive(0, 1, 0, enc_r(7'b0, 5'd1, 5'd1, 3'b000, 5'd7));
        for (int c = 0; c < 2; c++) begin
            total++;
            if (o_st[0] !== 1'b1 || o_st[1] !== 1'b0) begin
                bad++; $display("FAIL mul_stall%0d got en=%b dis=%b want 1 0", c, o_st[0], o_st[1]);
            end
            tick();
            total++;
            if (o_v[0] !== 1'b0) begin bad++; $display("FAIL mul_bubble%0d got v=%b want 0", c, o_v[0]); end
        end
        total++;
        if (o_st[0] !== 1'b0) begin bad++; $display("FAIL mul_release got=%b want=0", o_st[0]); end
        tick();
        total++;
        if (o_op[0] !== 4'b1000 || o_rd[0] !== 5'd7 || o_v[0] !== 1'b1) begin
            bad++; $display("FAIL mul_next got op=%b rd=%0d v=%b want 1000 7 1", o_op[0], o_rd[0], o_v[0]);
        end
    endtask

    task automatic test_flush();
        drive(0, 1, 0, enc_lw(5'd2, 5'd1));
        tick();
        drive(0, 1, 1, enc_r(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd3));
        total++;
        if (o_st[0] !== 1'b1) begin bad++; $display("FAIL flush_stall got=%b want=1", o_st[0]); end
        tick();
        total++;
        if (o_v[0] !== 1'b0 || o_rw[0] !== 1'b0 || o_op[0] !== 4'b0000) begin
            bad++; $display("FAIL flush_bubble got v=%b rw=%b op=%b want 0 0 0000", o_v[0], o_rw[0], o_op[0]);
        end
        drive(0, 0, 0, enc_beq(5'd1, 5'd2));
        tick();
        total++;
        if (o_v[0] !== 1'b0) begin bad++; $display("FAIL flush_nosub got v=%b want 0", o_v[0]); end
    endtask

    task automatic test_reset_mid_stall();
        drive(0, 1, 0, enc_r(7'b0000001, 5'd6, 5'd5, 3'b000, 5'd4));
        tick();
        drive(0, 1, 0, enc_r(7'b0, 5'd1, 5'd1, 3'b000, 5'd7));
        tick();
        drive(1, 1, 0, enc_r(7'b0, 5'd1, 5'd1, 3'b000, 5'd7));
        total++;
        if (o_st[0] !== 1'b1) begin bad++; $display("FAIL rms_stall got=%b want=1", o_st[0]); end
        tick();
        total++;
        if (obs(0) !== exp_t'(0)) begin bad++; $display("FAIL rms_ex got=%h want=0000", obs(0)); end
        drive(0, 1, 0, enc_r(7'b0, 5'd1, 5'd1, 3'b000, 5'd7));
        total++;
        if (o_st[0] !== 1'b0) begin bad++; $display("FAIL rms_stall_drop got=%b want=0", o_st[0]); end
        tick();
        total++;
        if (o_v[0] !== 1'b1 || o_rd[0] !== 5'd7) begin
            bad++; $display("FAIL rms_add got v=%b rd=%0d want 1 7", o_v[0], o_rd[0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [4:0]  ra, rb, rc;
        for (int i = 0; i < 400; i++) begin
            ra = 5'($urandom_range(0, 3));
            rb = 5'($urandom_range(0, 3));
            rc = 5'($urandom_range(0, 3));
            case ($urandom_range(0, 8))
                0: ins = enc_addi(rc, ra, 12'($urandom));
                1: ins = enc_lw(rc, ra);
                2: ins = enc_sw(rb, ra);
                3: ins = enc_beq(ra, rb);
                4: ins = enc_r(7'b0100000, rb, ra, 3'($urandom), rc);
                5: ins = enc_r(7'b0000001, rb, ra, 3'($urandom), rc);
                6: ins = enc_r(7'b0000000, rb, ra, 3'($urandom), rc);
                7: ins = {$urandom} & 32'hFFFF_FF80 | 32'h37;
                default: ins = enc_lw(rc, ra);
            endcase
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
                  ($urandom_range(0, 9) == 0), ins);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (o_st[k] !== model_stall(k)) begin
                    bad++; $display("FAIL rnd_stall[%0d] i=%0d got=%b want=%b", k, i, o_st[k], model_stall(k));
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs(k) !== m[k]) begin
                    bad++; $display("FAIL rnd_ex[%0d] i=%0d got=%h want=%h", k, i, obs(k), m[k]);
                end
            end
        end
    endtask

    initial begin
        m    = '{default: '0};
        busy = '{default: 0};
        drive(1, 0, 0, 32'h0);
        test_reset();
        test_addi();
        test_load_use();
        test_x0_and_sw();
        test_mul();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
